// File: rtl/binary_mul_pkg.sv
// Shared FSM state type and default operand width for the iterative
// shift-add multiplier.
package binary_mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int WIDTH_DEFAULT = 8;

endpackage

// File: rtl/binary_mul_iter_if.sv
// Operand/result handshake bundle of the iterative multiplier; the master
// presents operands and consumes the product, the slave is the multiplier.
interface binary_mul_iter_if #(
    parameter int WIDTH = binary_mul_pkg::WIDTH_DEFAULT
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic               sgn;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] P;

    modport master (
        output in_valid, A, B, sgn, out_ready,
        input  in_ready, out_valid, P
    );

    modport slave (
        input  in_valid, A, B, sgn, out_ready,
        output in_ready, out_valid, P
    );

endinterface

// File: rtl/binary_mul_iter_mul_step.sv
// One radix-2 multiply step: conditionally add (or subtract) the extended
// multiplicand into the WIDTH+1 bit partial sum, then shift right by one.
module mul_step
    import binary_mul_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] a,
    input  logic             mbit,
    input  logic             sgn,
    input  logic             sub,
    output logic [WIDTH:0]   acc_next,
    output logic             lsb
);

    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] addend;
    logic [WIDTH:0] sum;

    // NOTE: every output of a combinational block gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        a_ext    = {sgn & a[WIDTH-1], a};
        addend   = mbit ? a_ext : '0;
        sum      = sub ? (acc - addend) : (acc + addend);
        // The extra top bit keeps every signed partial sum in range, so the
        // shift-in is simply its sign (or zero for unsigned operands).
        acc_next = {sgn & sum[WIDTH], sum[WIDTH:1]};
        lsb      = sum[0];
    end

endmodule

// File: rtl/binary_mul_iter.sv
// Iterative WIDTH x WIDTH multiplier, signed or unsigned per operation, one
// shift-add step per enabled clock with valid/ready handshakes on both sides.
module binary_mul_iter
    import binary_mul_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    binary_mul_iter_if.slave  bus
);

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t             state;
    state_t             state_next;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   mq;
    logic               sgn_r;
    logic [WIDTH:0]     acc;
    logic [WIDTH:0]     acc_next;
    logic               step_lsb;
    logic               last_step;
    logic               accept;
    logic [2*WIDTH-1:0] p_r;

    assign last_step = (cnt == LAST);
    assign accept    = bus.in_valid & bus.in_ready;
    assign bus.P     = p_r;

    // The multiplier MSB carries negative weight in two's complement, so the
    // final signed step subtracts instead of adding.
    mul_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc      (acc),
        .a        (a_r),
        .mbit     (mq[0]),
        .sgn      (sgn_r),
        .sub      (sgn_r & last_step),
        .acc_next (acc_next),
        .lsb      (step_lsb)
    );

    // NOTE: sequential state is written with non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (en) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = en;
                if (accept) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Low product bits shift into the vacated top of mq as multiplier bits
    // are consumed, so after WIDTH steps {acc, mq} holds the full product.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            a_r   <= '0;
            mq    <= '0;
            sgn_r <= 1'b0;
            acc   <= '0;
            p_r   <= '0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_r   <= bus.A;
                        mq    <= bus.B;
                        sgn_r <= bus.sgn;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    mq  <= {step_lsb, mq[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    if (last_step) begin
                        p_r <= {acc_next[WIDTH-1:0], step_lsb, mq[WIDTH-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
